// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite slave register bank: NUM_REGS 32-bit registers, the last one read-only
// and mirroring hw_status; independent write (AW/W holding slots) and read paths.
module axi_lite_reg_slave #(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [31:0]              S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  input  logic [31:0]              hw_status,
  output logic [32*NUM_REGS-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned LAST  = NUM_REGS - 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic [31:0]       regs_q [NUM_REGS];
  logic [31:0]       regs_d [NUM_REGS];
  logic              aw_held_q, aw_held_d;
  logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
  logic              aw_oor_q, aw_oor_d;
  logic              w_held_q, w_held_d;
  logic [31:0]       w_data_q, w_data_d;
  logic [3:0]        w_strb_q, w_strb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  logic              awready_c, wready_c, arready_c;
  logic              aw_hs_c, w_hs_c, ar_hs_c;
  logic [IDX_W-1:0]  aw_idx_in_c, ar_idx_c, cmt_idx_c;
  logic              aw_oor_in_c, ar_oor_c, cmt_oor_c;
  logic [31:0]       cmt_data_c;
  logic [3:0]        cmt_strb_c;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Readies are combinational from registered state and forced low in reset.
  assign awready_c = !rst && !aw_held_q && !bvalid_q;
  assign wready_c  = !rst && !w_held_q && !bvalid_q;
  assign arready_c = !rst && !rvalid_q;

  assign aw_hs_c = S_AXI_AWVALID && awready_c;
  assign w_hs_c  = S_AXI_WVALID && wready_c;
  assign ar_hs_c = S_AXI_ARVALID && arready_c;

  assign aw_idx_in_c = S_AXI_AWADDR[IDX_W+1:2];
  assign aw_oor_in_c = (S_AXI_AWADDR[31:IDX_W+2] != '0);
  assign ar_idx_c    = S_AXI_ARADDR[IDX_W+1:2];
  assign ar_oor_c    = (S_AXI_ARADDR[31:IDX_W+2] != '0);

  // A slot filled this cycle feeds the commit directly so AW+W in one cycle commits at once.
  assign cmt_idx_c  = aw_held_q ? aw_idx_q : aw_idx_in_c;
  assign cmt_oor_c  = aw_held_q ? aw_oor_q : aw_oor_in_c;
  assign cmt_data_c = w_held_q ? w_data_q : S_AXI_WDATA;
  assign cmt_strb_c = w_held_q ? w_strb_q : S_AXI_WSTRB;

  always_comb begin
    regs_d     = regs_q;
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    aw_oor_d   = aw_oor_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    wr_pulse_d = '0;

    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;

    if (aw_hs_c) begin
      aw_held_d = 1'b1;
      aw_idx_d  = aw_idx_in_c;
      aw_oor_d  = aw_oor_in_c;
    end
    if (w_hs_c) begin
      w_held_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end

    if ((aw_held_q || aw_hs_c) && (w_held_q || w_hs_c)) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (!cmt_oor_c && (cmt_idx_c != IDX_W'(LAST))) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (cmt_strb_c[b]) regs_d[cmt_idx_c][8*b +: 8] = cmt_data_c[8*b +: 8];
        end
        wr_pulse_d[cmt_idx_c] = 1'b1;
        bresp_d = RESP_OKAY;
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end

    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;

    // Reads sample the pre-commit register value at the handshake edge.
    if (ar_hs_c) begin
      rvalid_d = 1'b1;
      if (ar_oor_c) begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end else if (ar_idx_c == IDX_W'(LAST)) begin
        rdata_d = hw_status;
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = regs_q[ar_idx_c];
        rresp_d = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      aw_oor_q   <= 1'b0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      aw_oor_q   <= aw_oor_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  assign S_AXI_AWREADY = awready_c;
  assign S_AXI_WREADY  = wready_c;
  assign S_AXI_ARREADY = arready_c;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_pulse      = wr_pulse_q;

  // The read-only slot is reported as zero on the flat output.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    if (i == int'(LAST)) begin : g_ro
      assign reg_out[32*i +: 32] = '0;
    end else begin : g_rw
      assign reg_out[32*i +: 32] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: a transaction-level model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_axi_lite_reg_slave;

  localparam int unsigned NR = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       S_AXI_AWADDR = '0;
  logic              S_AXI_AWVALID = 1'b0;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA = '0;
  logic [3:0]        S_AXI_WSTRB = '0;
  logic              S_AXI_WVALID = 1'b0;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY = 1'b0;
  logic [31:0]       S_AXI_ARADDR = '0;
  logic              S_AXI_ARVALID = 1'b0;
  logic              S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY = 1'b0;
  logic [31:0]       hw_status = '0;
  logic [32*NR-1:0]  reg_out;
  logic [NR-1:0]     wr_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  axi_lite_reg_slave #(.NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .hw_status(hw_status),
    .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL timeout %s: got no handshake expected one within 20 cycles at %0t", what, $time);
  endtask

  // Model state: register contents, pending AW/W entries, outstanding responses.
  logic [31:0] m_reg [NR];
  logic [31:0] aw_q [$];
  logic [35:0] w_q [$];
  logic        m_b = 1'b0;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_r = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = 2'b00;
  logic [NR-1:0] m_pulse = '0;
  logic        p_aw, p_w, p_ar;
  logic [31:0] p_a;
  logic [35:0] p_wd;
  int          p_idx;
  logic [32*NR-1:0] p_flat;

  // Compare DUT against the model, then predict the effect of the coming rising edge.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NR); i++) m_reg[i] = '0;
      aw_q.delete();
      w_q.delete();
      m_b = 1'b0; m_bresp = 2'b00;
      m_r = 1'b0; m_rdata = '0; m_rresp = 2'b00;
      m_pulse = '0;
    end
    for (int i = 0; i < int'(NR); i++) p_flat[32*i +: 32] = m_reg[i];
    chk("awready", 512'(S_AXI_AWREADY), 512'(!rst && aw_q.size() == 0 && !m_b));
    chk("wready",  512'(S_AXI_WREADY),  512'(!rst && w_q.size() == 0 && !m_b));
    chk("arready", 512'(S_AXI_ARREADY), 512'(!rst && !m_r));
    chk("bvalid",  512'(S_AXI_BVALID),  512'(m_b));
    chk("bresp",   512'(S_AXI_BRESP),   512'(m_bresp));
    chk("rvalid",  512'(S_AXI_RVALID),  512'(m_r));
    chk("rdata",   512'(S_AXI_RDATA),   512'(m_rdata));
    chk("rresp",   512'(S_AXI_RRESP),   512'(m_rresp));
    chk("reg_out", 512'(reg_out),       512'(p_flat));
    chk("wr_pulse", 512'(wr_pulse),     512'(m_pulse));
    if (!rst) begin
      p_aw = S_AXI_AWVALID && aw_q.size() == 0 && !m_b;
      p_w  = S_AXI_WVALID && w_q.size() == 0 && !m_b;
      p_ar = S_AXI_ARVALID && !m_r;
      if (m_b && S_AXI_BREADY) m_b = 1'b0;
      if (m_r && S_AXI_RREADY) m_r = 1'b0;
      if (p_ar) begin
        m_r = 1'b1;
        if (S_AXI_ARADDR >= 32'(4 * NR)) begin
          m_rdata = '0; m_rresp = 2'b10;
        end else begin
          p_idx = int'(S_AXI_ARADDR / 4);
          m_rdata = (p_idx == int'(NR) - 1) ? hw_status : m_reg[p_idx];
          m_rresp = 2'b00;
        end
      end
      if (p_aw) aw_q.push_back(S_AXI_AWADDR);
      if (p_w)  w_q.push_back({S_AXI_WSTRB, S_AXI_WDATA});
      m_pulse = '0;
      if (aw_q.size() > 0 && w_q.size() > 0) begin
        p_a  = aw_q.pop_front();
        p_wd = w_q.pop_front();
        m_b  = 1'b1;
        if (p_a < 32'(4 * NR) && int'(p_a / 4) != int'(NR) - 1) begin
          p_idx = int'(p_a / 4);
          for (int b = 0; b < 4; b++)
            if (p_wd[32 + b]) m_reg[p_idx][8*b +: 8] = p_wd[8*b +: 8];
          m_pulse[p_idx] = 1'b1;
          m_bresp = 2'b00;
        end else begin
          m_bresp = 2'b10;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    output logic [1:0] resp);
    int n = 0;
    logic a_hs, w_hs;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 20) begin
      a_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      if (a_hs) S_AXI_AWVALID = 1'b0;
      if (w_hs) S_AXI_WVALID = 1'b0;
      n++;
    end
    if (n >= 20) tmo("write address/data");
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin tick(); n++; end
    if (n >= 20) tmo("bvalid");
    resp = S_AXI_BRESP;
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    S_AXI_ARADDR = addr;
    S_AXI_ARVALID = 1'b1;
    while (!S_AXI_ARREADY && n < 20) begin tick(); n++; end
    if (n >= 20) tmo("arready");
    tick();
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin tick(); n++; end
    if (n >= 20) tmo("rvalid");
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
  endtask

  logic [31:0] d;
  logic [1:0]  r;

  initial begin
    // Reset and idle
    repeat (2) tick();
    chk("rst awready", 512'(S_AXI_AWREADY), 512'(0));
    chk("rst wready",  512'(S_AXI_WREADY),  512'(0));
    chk("rst arready", 512'(S_AXI_ARREADY), 512'(0));
    chk("rst reg_out", 512'(reg_out), 512'(0));
    rst = 1'b0;
    #1;
    chk("post-rst awready", 512'(S_AXI_AWREADY), 512'(1));
    chk("post-rst wready",  512'(S_AXI_WREADY),  512'(1));
    chk("post-rst arready", 512'(S_AXI_ARREADY), 512'(1));
    tick();

    // AW and W in the same cycle to reg 1
    S_AXI_AWADDR = 32'h04; S_AXI_WDATA = 32'hA5A5_1234; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("reg1 value", 512'(reg_out[63:32]), 512'(32'hA5A5_1234));
    chk("reg1 pulse", 512'(wr_pulse), 512'(16'h0002));
    chk("reg1 bvalid", 512'(S_AXI_BVALID), 512'(1));
    chk("reg1 bresp", 512'(S_AXI_BRESP), 512'(2'b00));
    tick();
    chk("reg1 pulse gone", 512'(wr_pulse), 512'(0));
    S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;
    rd(32'h04, d, r);
    chk("read reg1 data", 512'(d), 512'(32'hA5A5_1234));
    chk("read reg1 resp", 512'(r), 512'(2'b00));

    // W two cycles ahead of AW, partial strobe on reg 2
    wr(32'h08, 32'h1122_3344, 4'hF, r);
    chk("reg2 init", 512'(reg_out[95:64]), 512'(32'h1122_3344));
    S_AXI_WDATA = 32'hFFFF_FFFF; S_AXI_WSTRB = 4'b0101; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_WVALID = 1'b0;
    chk("w-only bvalid", 512'(S_AXI_BVALID), 512'(0));
    tick();
    chk("w-only bvalid 2", 512'(S_AXI_BVALID), 512'(0));
    S_AXI_AWADDR = 32'h08; S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    chk("late aw bvalid", 512'(S_AXI_BVALID), 512'(1));
    chk("reg2 merged", 512'(reg_out[95:64]), 512'(32'h11FF_33FF));
    S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;

    // Read-only and out-of-range accesses
    wr(32'h3C, 32'hDEAD_BEEF, 4'hF, r);
    chk("ro write bresp", 512'(r), 512'(2'b10));
    wr(32'h40, 32'hDEAD_BEEF, 4'hF, r);
    chk("oor write bresp", 512'(r), 512'(2'b10));
    chk("ro slot zero", 512'(reg_out[511:480]), 512'(0));
    hw_status = 32'hCAFE_0001;
    rd(32'h3C, d, r);
    chk("ro read data", 512'(d), 512'(32'hCAFE_0001));
    chk("ro read resp", 512'(r), 512'(2'b00));
    rd(32'h40, d, r);
    chk("oor read data", 512'(d), 512'(0));
    chk("oor read resp", 512'(r), 512'(2'b10));

    // BREADY held low for five cycles
    S_AXI_AWADDR = 32'h10; S_AXI_WDATA = 32'h5555_AAAA; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold bvalid", 512'(S_AXI_BVALID), 512'(1));
      chk("hold bresp", 512'(S_AXI_BRESP), 512'(2'b00));
      chk("hold awready", 512'(S_AXI_AWREADY), 512'(0));
      chk("hold wready", 512'(S_AXI_WREADY), 512'(0));
      tick();
    end
    S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;
    chk("after b bvalid", 512'(S_AXI_BVALID), 512'(0));
    chk("after b awready", 512'(S_AXI_AWREADY), 512'(1));
    chk("after b wready", 512'(S_AXI_WREADY), 512'(1));

    // Commit and read of reg 3 at the same edge
    S_AXI_AWADDR = 32'h0C; S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 32'h0C;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    chk("same-edge rdata", 512'(S_AXI_RDATA), 512'(0));
    chk("same-edge rvalid", 512'(S_AXI_RVALID), 512'(1));
    chk("same-edge reg3", 512'(reg_out[127:96]), 512'(32'h77));
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    rd(32'h0C, d, r);
    chk("reread reg3", 512'(d), 512'(32'h77));

    // Reset while a read response is pending
    S_AXI_ARADDR = 32'h0C; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    chk("pre-rst rvalid", 512'(S_AXI_RVALID), 512'(1));
    rst = 1'b1;
    #1;
    chk("mid-rst rvalid", 512'(S_AXI_RVALID), 512'(0));
    chk("mid-rst reg_out", 512'(reg_out), 512'(0));
    chk("mid-rst awready", 512'(S_AXI_AWREADY), 512'(0));
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("re-release arready", 512'(S_AXI_ARREADY), 512'(1));
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_slave.md
# axi_lite_reg_slave

AXI-Lite slave register bank that terminates the transactions issued by the team's AXI-Lite master. It exposes NUM_REGS 32-bit control/status registers to fabric logic. The last register is read-only and mirrors a hardware status input. It sits directly downstream of the master's M_AXI_* ports and drives flat register outputs plus per-register write strobes into the datapath.

## Interface
- NUM_REGS, 16: number of 32-bit registers, power of two, 2..256; index = S_AXI_*ADDR[IDX_W+1:2], IDX_W = log2(NUM_REGS).
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- S_AXI_AWADDR  in  32  write address
- S_AXI_AWVALID  in  1  / S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  32 / S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  32 / S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1
- hw_status  in  32  value returned by register NUM_REGS-1
- reg_out  out  32*NUM_REGS  flat register contents, reg i at [32i+31:32i]; slot NUM_REGS-1 = 0
- wr_pulse  out  NUM_REGS  one-cycle strobe per register written

## Operation
- Address decode: bits [1:0] ignored. Bits above IDX_W+1 nonzero = out of range.
- Write path uses two holding slots, aw_held (addr) and w_held (data, strobe). Each is filled independently on its own handshake, in either order or in the same cycle.
- AWREADY = !rst && !aw_held && !BVALID. WREADY = !rst && !w_held && !BVALID. Both are combinational from registered state.
- Commit occurs at the edge where both slots become/are full (both handshakes in one cycle is allowed).
  - Valid writable index: bytes with WSTRB[b]=1 update, the rest keep their value. wr_pulse[idx] is high for the following cycle. BRESP=00.
  - Out of range or index NUM_REGS-1: no register change, no wr_pulse. BRESP=10 (SLVERR).
  - At commit, BVALID goes high and both slots clear.
- BVALID and BRESP are held stable until the BVALID&&BREADY edge. BVALID then drops, and AWREADY/WREADY reopen in the next cycle.
- Read path: ARREADY = !rst && !RVALID.
  - On AR handshake, register RDATA = reg[idx] (hw_status for NUM_REGS-1, sampled at that edge), RRESP=00.
  - Out of range: RDATA=0, RRESP=10.
  - RVALID is held until the RVALID&&RREADY edge.
- Read and write paths are fully independent. A read and a commit to the same register at the same edge return the old value.
- Reset mid-transaction: all held slots, pending responses and partial writes are discarded. Registers return to 0.

## Timing
- Reset values: all registers 0, reg_out 0, wr_pulse 0, BVALID 0, BRESP 00, RVALID 0, RDATA 0, RRESP 00. Readies are 0 while rst is high and 1 in the first cycle after release.
- Write latency: BVALID rises 1 cycle after the later of AW/W handshakes. reg_out and wr_pulse change in that same cycle.
- Read latency: RVALID rises 1 cycle after the AR handshake.
- Throughput: 1 write per 2 cycles and 1 read per 2 cycles with BREADY/RREADY held high.
- A master asserting BREADY/RREADY only after seeing VALID (1-cycle lag) is supported. Responses simply hold.

## Test plan
- Reset then idle: all outputs match reset values, and AWREADY/WREADY/ARREADY = 1 one cycle after rst falls.
- AW+W same cycle: addr 0x04, data 0xA5A5_1234, strb 1111 -> next cycle reg_out[1] = 0xA5A5_1234, wr_pulse = 0x0002 for 1 cycle, BVALID = 1, BRESP = 00. A read of 0x04 then returns that value, RRESP = 00.
- W two cycles before AW, strb 0101, data 0xFFFF_FFFF to reg 2 (previously 0x1122_3344) -> 0x11FF_33FF. BVALID appears 1 cycle after the AW handshake, not before.
- Write to 0x3C (reg 15, read-only) and to 0x40 -> BRESP = 10, no wr_pulse, no reg_out change. Read 0x3C with hw_status = 0xCAFE_0001 returns it with RRESP = 00. Read 0x40 returns 0 with RRESP = 10.
- BREADY held low 5 cycles after BVALID -> BVALID/BRESP stable for all 5 cycles, and AWREADY/WREADY stay 0 until one cycle after the B handshake.
- Simultaneous commit and read to reg 3 (old value 0x0, new 0x77) -> RDATA = 0x0. A following read returns 0x77. Asserting rst mid-read clears RVALID immediately.
